// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: FSM states, op codes, error codes.
package atm_pkg;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StLang     = 4'd1,
        StPin      = 4'd2,
        StMenu     = 4'd3,
        StWithdraw = 4'd4,
        StDeposit  = 4'd5,
        StInquiry  = 4'd6,
        StMore     = 4'd7,
        StEject    = 4'd8
    } atm_state_e;

    localparam logic [1:0] OpWithdraw = 2'b00;
    localparam logic [1:0] OpDeposit  = 2'b01;
    localparam logic [1:0] OpInquiry  = 2'b10;
    localparam logic [1:0] OpExit     = 2'b11;

    localparam logic [2:0] ErrNone     = 3'd0;
    localparam logic [2:0] ErrPinWrong = 3'd1;
    localparam logic [2:0] ErrCardKept = 3'd2;
    localparam logic [2:0] ErrFunds    = 3'd3;
    localparam logic [2:0] ErrLimit    = 3'd4;
    localparam logic [2:0] ErrOverflow = 3'd5;
    localparam logic [2:0] ErrTimeout  = 3'd6;
    localparam logic [2:0] ErrZeroDep  = 3'd7;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Customer-facing request/response bundle of the ATM session controller.
interface atm_session_ctrl_if #(
    parameter int unsigned BAL_W = 20
);
    logic             card_in;
    logic [BAL_W-1:0] acct_balance;
    logic             lang_valid;
    logic             lang_sel;
    logic             pin_valid;
    logic             pin_ok;
    logic             op_valid;
    logic [1:0]       op;
    logic [BAL_W-1:0] amount;
    logic             more_valid;
    logic             more;
    logic [BAL_W-1:0] balance;
    logic             lang;
    logic [3:0]       state;
    logic             op_done;
    logic             err_valid;
    logic [2:0]       err_code;
    logic             card_out;
    logic             card_retained;

    // Host side: drives requests, observes session status.
    modport master (
        output card_in, acct_balance, lang_valid, lang_sel, pin_valid, pin_ok,
               op_valid, op, amount, more_valid, more,
        input  balance, lang, state, op_done, err_valid, err_code, card_out, card_retained
    );

    // Controller side.
    modport slave (
        input  card_in, acct_balance, lang_valid, lang_sel, pin_valid, pin_ok,
               op_valid, op, amount, more_valid, more,
        output balance, lang, state, op_done, err_valid, err_code, card_out, card_retained
    );
endinterface

// File: rtl/atm_timeout_timer.sv
// Per-state inactivity timer; expire holds once the count reaches TIMEOUT_CYC-1.
module atm_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expire
);
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] count_q, count_d;

    // Count up and saturate at the expiry value; clear wins.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != CntMax) begin
            count_d = count_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CntMax);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card, language, PIN, menu operations, ejection and timeouts.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned BAL_W       = 20,
    parameter int unsigned PIN_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned WD_LIMIT    = 5000
) (
    input  logic                clk,
    input  logic                rst,
    atm_session_ctrl_if.slave   bus
);
    localparam int unsigned TriesW = $clog2(PIN_TRIES + 1);
    localparam logic [TriesW-1:0] TriesMax = TriesW'(PIN_TRIES);
    localparam logic [BAL_W:0] WdLimit = (BAL_W + 1)'(WD_LIMIT);

    atm_state_e        state_q, state_d;
    logic [BAL_W-1:0]  balance_q, balance_d;
    logic [BAL_W-1:0]  amount_q, amount_d;
    logic [BAL_W:0]    withdrawn_q, withdrawn_d;
    logic [TriesW-1:0] tries_q, tries_d;
    logic              lang_q, lang_d;
    logic              op_done_q, op_done_d;
    logic              err_valid_q, err_valid_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              card_out_q, card_out_d;
    logic              card_retained_q, card_retained_d;

    logic              accepted;
    logic              expire;
    logic              timer_clear;
    logic [BAL_W:0]    bal_ext, amt_ext, wd_sum, dep_sum;
    logic [TriesW-1:0] tries_inc;

    // One extra bit so over-balance, limit and overflow tests never wrap.
    assign bal_ext   = {1'b0, balance_q};
    assign amt_ext   = {1'b0, amount_q};
    assign wd_sum    = withdrawn_q + amt_ext;
    assign dep_sum   = bal_ext + amt_ext;
    assign tries_inc = tries_q + TriesW'(1);

    assign timer_clear = accepted || (state_d != state_q);

    atm_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .expire (expire)
    );

    // Next-state, datapath updates and pulse generation.
    always_comb begin
        state_d         = state_q;
        balance_d       = balance_q;
        amount_d        = amount_q;
        withdrawn_d     = withdrawn_q;
        tries_d         = tries_q;
        lang_d          = lang_q;
        op_done_d       = 1'b0;
        err_valid_d     = 1'b0;
        err_code_d      = err_code_q;
        card_out_d      = 1'b0;
        card_retained_d = 1'b0;
        accepted        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.card_in) begin
                    accepted    = 1'b1;
                    state_d     = StLang;
                    balance_d   = bus.acct_balance;
                    tries_d     = '0;
                    withdrawn_d = '0;
                end
            end
            StLang: begin
                if (bus.lang_valid) begin
                    accepted = 1'b1;
                    state_d  = StPin;
                    lang_d   = bus.lang_sel;
                end else if (expire) begin
                    state_d     = StEject;
                    err_valid_d = 1'b1;
                    err_code_d  = ErrTimeout;
                end
            end
            StPin: begin
                if (bus.pin_valid) begin
                    accepted = 1'b1;
                    if (bus.pin_ok) begin
                        state_d = StMenu;
                        tries_d = '0;
                    end else begin
                        tries_d     = tries_inc;
                        err_valid_d = 1'b1;
                        if (tries_inc >= TriesMax) begin
                            // Card is swallowed: no card_out on this path.
                            state_d         = StIdle;
                            card_retained_d = 1'b1;
                            err_code_d      = ErrCardKept;
                        end else begin
                            err_code_d = ErrPinWrong;
                        end
                    end
                end else if (expire) begin
                    state_d     = StEject;
                    err_valid_d = 1'b1;
                    err_code_d  = ErrTimeout;
                end
            end
            StMenu: begin
                if (bus.op_valid) begin
                    accepted = 1'b1;
                    amount_d = bus.amount;
                    unique case (bus.op)
                        OpWithdraw: state_d = StWithdraw;
                        OpDeposit:  state_d = StDeposit;
                        OpInquiry:  state_d = StInquiry;
                        default:    state_d = StEject;
                    endcase
                end else if (expire) begin
                    state_d     = StEject;
                    err_valid_d = 1'b1;
                    err_code_d  = ErrTimeout;
                end
            end
            StWithdraw: begin
                state_d = StMore;
                if (amount_q == '0 || amt_ext > bal_ext) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ErrFunds;
                end else if (wd_sum > WdLimit) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ErrLimit;
                end else begin
                    // wd_sum <= WdLimit here, so the session total never passes the limit.
                    balance_d   = balance_q - amount_q;
                    withdrawn_d = wd_sum;
                    op_done_d   = 1'b1;
                end
            end
            StDeposit: begin
                state_d = StMore;
                if (amount_q == '0) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ErrZeroDep;
                end else if (dep_sum[BAL_W]) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ErrOverflow;
                end else begin
                    balance_d = dep_sum[BAL_W-1:0];
                    op_done_d = 1'b1;
                end
            end
            StInquiry: begin
                state_d   = StMore;
                op_done_d = 1'b1;
            end
            StMore: begin
                if (bus.more_valid) begin
                    accepted = 1'b1;
                    state_d  = bus.more ? StMenu : StEject;
                end else if (expire) begin
                    state_d     = StEject;
                    err_valid_d = 1'b1;
                    err_code_d  = ErrTimeout;
                end
            end
            StEject: begin
                state_d    = StIdle;
                card_out_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Session state registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            balance_q       <= '0;
            amount_q        <= '0;
            withdrawn_q     <= '0;
            tries_q         <= '0;
            lang_q          <= 1'b0;
            op_done_q       <= 1'b0;
            err_valid_q     <= 1'b0;
            err_code_q      <= ErrNone;
            card_out_q      <= 1'b0;
            card_retained_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            balance_q       <= balance_d;
            amount_q        <= amount_d;
            withdrawn_q     <= withdrawn_d;
            tries_q         <= tries_d;
            lang_q          <= lang_d;
            op_done_q       <= op_done_d;
            err_valid_q     <= err_valid_d;
            err_code_q      <= err_code_d;
            card_out_q      <= card_out_d;
            card_retained_q <= card_retained_d;
        end
    end

    assign bus.balance       = balance_q;
    assign bus.lang          = lang_q;
    assign bus.state         = state_q;
    assign bus.op_done       = op_done_q;
    assign bus.err_valid     = err_valid_q;
    assign bus.err_code      = err_code_q;
    assign bus.card_out      = card_out_q;
    assign bus.card_retained = card_retained_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed scenarios plus randomized sessions vs a reference model.
module tb_atm_session_ctrl;
    import atm_pkg::*;

    localparam int unsigned BAL_W       = 20;
    localparam int unsigned PIN_TRIES   = 3;
    localparam int unsigned TIMEOUT_CYC = 32;
    localparam int unsigned WD_LIMIT    = 5000;
    localparam longint      BalMod      = longint'(1) << BAL_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    atm_session_ctrl_if #(.BAL_W(BAL_W)) bus ();

    atm_session_ctrl #(
        .BAL_W       (BAL_W),
        .PIN_TRIES   (PIN_TRIES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .WD_LIMIT    (WD_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Observed pulse counts.
    int n_op_done = 0, n_err = 0, n_card_out = 0, n_retained = 0;

    // Reference model of the session.
    logic [3:0] m_state = StIdle;
    longint     m_bal = 0, m_wd = 0;
    int         m_tries = 0;
    logic       m_lang = 1'b0;
    logic [2:0] m_err = ErrNone;
    int         e_op_done = 0, e_err = 0, e_card_out = 0, e_retained = 0;

    // Pulses last exactly one cycle, so one sample per falling edge counts each once.
    always @(negedge clk) begin
        if (bus.op_done === 1'b1)       n_op_done  <= n_op_done + 1;
        if (bus.err_valid === 1'b1)     n_err      <= n_err + 1;
        if (bus.card_out === 1'b1)      n_card_out <= n_card_out + 1;
        if (bus.card_retained === 1'b1) n_retained <= n_retained + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},    64'(bus.state), 64'(m_state));
        check({tag, ".balance"},  64'(bus.balance), m_bal);
        check({tag, ".lang"},     64'(bus.lang), 64'(m_lang));
        check({tag, ".err_code"}, 64'(bus.err_code), 64'(m_err));
        check({tag, ".n_done"},   n_op_done, e_op_done);
        check({tag, ".n_err"},    n_err, e_err);
        check({tag, ".n_out"},    n_card_out, e_card_out);
        check({tag, ".n_kept"},   n_retained, e_retained);
    endtask

    // Inputs change 1 time unit after a rising edge and are held across the next one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_err(input logic [2:0] code);
        e_err++;
        m_err = code;
    endtask

    task automatic do_card(input longint bal);
        bus.card_in      = 1'b1;
        bus.acct_balance = bal[BAL_W-1:0];
        tick(1);
        bus.card_in = 1'b0;
        if (m_state == StIdle) begin
            m_state = StLang;
            m_bal   = bal;
            m_wd    = 0;
            m_tries = 0;
        end
    endtask

    task automatic do_lang(input logic sel);
        bus.lang_valid = 1'b1;
        bus.lang_sel   = sel;
        tick(1);
        bus.lang_valid = 1'b0;
        if (m_state == StLang) begin
            m_lang  = sel;
            m_state = StPin;
        end
    endtask

    task automatic do_pin(input logic ok);
        bus.pin_valid = 1'b1;
        bus.pin_ok    = ok;
        tick(1);
        bus.pin_valid = 1'b0;
        if (m_state == StPin) begin
            if (ok) begin
                m_tries = 0;
                m_state = StMenu;
            end else begin
                m_tries++;
                if (m_tries >= PIN_TRIES) begin
                    model_err(ErrCardKept);
                    e_retained++;
                    m_state = StIdle;
                end else begin
                    model_err(ErrPinWrong);
                end
            end
        end
        tick(1);
    endtask

    // Whole operation at transaction level: outcome once the one-cycle op state is done.
    task automatic model_op(input logic [1:0] op, input longint amt);
        case (op)
            OpWithdraw: begin
                if (amt == 0 || amt > m_bal)       model_err(ErrFunds);
                else if (m_wd + amt > WD_LIMIT)    model_err(ErrLimit);
                else begin
                    m_bal -= amt;
                    m_wd  += amt;
                    e_op_done++;
                end
                m_state = StMore;
            end
            OpDeposit: begin
                if (amt == 0)                      model_err(ErrZeroDep);
                else if (m_bal + amt >= BalMod)    model_err(ErrOverflow);
                else begin
                    m_bal += amt;
                    e_op_done++;
                end
                m_state = StMore;
            end
            OpInquiry: begin
                e_op_done++;
                m_state = StMore;
            end
            default: begin
                e_card_out++;
                m_state = StIdle;
            end
        endcase
    endtask

    task automatic do_op(input logic [1:0] op, input longint amt_in);
        longint amt;
        amt          = amt_in % BalMod;
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.amount   = amt[BAL_W-1:0];
        tick(1);
        bus.op_valid = 1'b0;
        if (m_state == StMenu) model_op(op, amt);
        tick(2);
    endtask

    task automatic do_more(input logic m);
        bus.more_valid = 1'b1;
        bus.more       = m;
        tick(1);
        bus.more_valid = 1'b0;
        if (m_state == StMore) begin
            if (m) m_state = StMenu;
            else begin
                m_state = StIdle;
                e_card_out++;
            end
        end
        tick(2);
    endtask

    // Valids that do not belong to MENU, plus a stray card_in; none may have any effect.
    task automatic poke_ignored();
        bus.card_in      = 1'b1;
        bus.acct_balance = BAL_W'($urandom());
        bus.lang_valid   = 1'b1;
        bus.lang_sel     = ~m_lang;
        bus.pin_valid    = 1'b1;
        bus.pin_ok       = 1'b0;
        bus.more_valid   = 1'b1;
        bus.more         = 1'b0;
        tick(1);
        bus.card_in    = 1'b0;
        bus.lang_valid = 1'b0;
        bus.pin_valid  = 1'b0;
        bus.more_valid = 1'b0;
    endtask

    function automatic longint pick_amount();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return longint'($urandom_range(1, 500));
            2:       return m_bal;
            3:       return m_bal + 1;
            4:       return longint'($urandom_range(1, 6000));
            default: return longint'($urandom()) % BalMod;
        endcase
    endfunction

    task automatic random_session();
        longint     bal;
        int         r;
        logic [1:0] op;
        case ($urandom_range(0, 3))
            0:       bal = longint'($urandom_range(0, 2000));
            1:       bal = longint'($urandom_range(0, 20000));
            2:       bal = BalMod - 1 - longint'($urandom_range(0, 100));
            default: bal = longint'($urandom()) % BalMod;
        endcase
        do_card(bal);
        do_lang(1'($urandom_range(0, 1)));
        check_all("rnd.lang");
        while (m_state == StPin) begin
            do_pin($urandom_range(0, 3) != 0);
            check_all("rnd.pin");
        end
        for (int k = 0; k < 8 && m_state == StMenu; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                poke_ignored();
                check_all("rnd.ignored");
            end
            r  = int'($urandom_range(0, 9));
            op = (r < 4) ? OpWithdraw : (r < 7) ? OpDeposit : (r < 9) ? OpInquiry : OpExit;
            do_op(op, pick_amount());
            check_all("rnd.op");
            if (m_state == StMore) begin
                do_more($urandom_range(0, 3) != 0);
                check_all("rnd.more");
            end
        end
        if (m_state == StMenu) begin
            do_op(OpExit, 0);
            check_all("rnd.exit");
        end
    endtask

    initial begin
        bus.card_in      = 1'b0;
        bus.acct_balance = '0;
        bus.lang_valid   = 1'b0;
        bus.lang_sel     = 1'b0;
        bus.pin_valid    = 1'b0;
        bus.pin_ok       = 1'b0;
        bus.op_valid     = 1'b0;
        bus.op           = 2'b00;
        bus.amount       = '0;
        bus.more_valid   = 1'b0;
        bus.more         = 1'b0;

        // Reset state.
        #2 rst = 1'b0;
        #1;
        check_all("reset");
        tick(2);
        rst = 1'b1;
        tick(1);
        check_all("reset.rel");

        // Basic withdraw session.
        do_card(1000);
        do_lang(1'b0);
        do_pin(1'b1);
        check_all("t033.menu");
        do_op(OpWithdraw, 300);
        check("t033.bal", 64'(bus.balance), 700);
        check_all("t033.wd");
        do_more(1'b0);
        check("t033.state", 64'(bus.state), 64'(StIdle));
        check_all("t033.end");

        // Three wrong PINs: card retained, no ejection.
        do_card(500);
        do_lang(1'b1);
        do_pin(1'b0);
        check("t034.err1", 64'(bus.err_code), 1);
        do_pin(1'b0);
        check("t034.err2", 64'(bus.err_code), 1);
        do_pin(1'b0);
        check("t034.err3", 64'(bus.err_code), 2);
        check_all("t034.end");

        // Insufficient funds, then session withdrawal limit.
        do_card(1000);
        do_lang(1'b0);
        do_pin(1'b1);
        do_op(OpWithdraw, 1200);
        check("t035.err", 64'(bus.err_code), 3);
        check("t035.bal", 64'(bus.balance), 1000);
        check_all("t035.a");
        do_more(1'b0);
        do_card(9000);
        do_lang(1'b0);
        do_pin(1'b1);
        do_op(OpWithdraw, 4000);
        do_more(1'b1);
        do_op(OpWithdraw, 2000);
        check("t035.lim", 64'(bus.err_code), 4);
        check("t035.bal2", 64'(bus.balance), 5000);
        check_all("t035.b");
        do_more(1'b0);

        // Deposit overflow, then deposit up to just under the top.
        do_card(BalMod - 10);
        do_lang(1'b1);
        do_pin(1'b1);
        do_op(OpDeposit, 20);
        check("t036.err", 64'(bus.err_code), 5);
        check("t036.bal", 64'(bus.balance), 64'(BalMod - 10));
        do_more(1'b1);
        do_op(OpDeposit, 5);
        check("t036.bal2", 64'(bus.balance), 64'(BalMod - 5));
        check_all("t036");
        do_more(1'b0);

        // MENU timeout: still in MENU one cycle before expiry, ejected after.
        do_card(100);
        do_lang(1'b0);
        do_pin(1'b1);
        tick(TIMEOUT_CYC - 2);
        check("t037.pre", 64'(bus.state), 64'(StMenu));
        tick(3);
        model_err(ErrTimeout);
        e_card_out++;
        m_state = StIdle;
        check_all("t037.to");

        // Operation arriving on the expiry cycle is taken instead of the timeout.
        do_card(100);
        do_lang(1'b0);
        do_pin(1'b1);
        tick(TIMEOUT_CYC - 2);
        bus.op_valid = 1'b1;
        bus.op       = OpInquiry;
        tick(1);
        bus.op_valid = 1'b0;
        check("t037.win", 64'(bus.state), 64'(StInquiry));
        model_op(OpInquiry, 0);
        tick(2);
        check_all("t037.win2");
        do_more(1'b0);

        // Reset in the middle of a withdrawal.
        do_card(2000);
        do_lang(1'b1);
        do_pin(1'b1);
        bus.op_valid = 1'b1;
        bus.op       = OpWithdraw;
        bus.amount   = 500;
        tick(1);
        bus.op_valid = 1'b0;
        check("t038.wd", 64'(bus.state), 64'(StWithdraw));
        #1 rst = 1'b0;
        #1;
        m_state = StIdle;
        m_bal   = 0;
        m_lang  = 1'b0;
        m_err   = ErrNone;
        check("t038.dv", 64'(bus.op_done), 0);
        check("t038.ev", 64'(bus.err_valid), 0);
        check("t038.co", 64'(bus.card_out), 0);
        check("t038.cr", 64'(bus.card_retained), 0);
        check_all("t038.rst");
        #1 rst = 1'b1;
        tick(1);
        check_all("t038.rel");

        for (int s = 0; s < 40; s++) random_session();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 SHALL have parameter BAL_W, default 20, balance/amount width in bits.
REQ-002 SHALL have parameter PIN_TRIES, default 3, wrong-PIN attempts before card retention.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, idle cycles per state before session abort.
REQ-004 SHALL have parameter WD_LIMIT, default 5000, maximum cumulative withdrawal per session.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports: clk  in  1  clock, rising edge.
REQ-007 Ports: rst  in  1  asynchronous active-low reset.
REQ-008 Ports: card_in  in  1  card inserted pulse; acct_balance  in  BAL_W  balance sampled with card_in.
REQ-009 Ports: lang_valid  in  1, lang_sel  in  1  (1 Arabic, 0 English).
REQ-010 Ports: pin_valid  in  1, pin_ok  in  1  PIN check result.
REQ-011 Ports: op_valid  in  1, op  in  2  (00 withdraw, 01 deposit, 10 inquiry, 11 exit), amount  in  BAL_W.
REQ-012 Ports: more_valid  in  1, more  in  1  another-service answer.
REQ-013 Ports: balance  out  BAL_W; lang  out  1; state  out  4; op_done  out  1; err_valid  out  1; err_code  out  3; card_out  out  1; card_retained  out  1.

Function
REQ-014 SHALL implement states IDLE, LANG, PIN, MENU, WITHDRAW, DEPOSIT, INQUIRY, MORE, EJECT; state output carries encoding.
REQ-015 IDLE: card_in -> LANG, balance <= acct_balance, tries and session withdrawal cleared; other inputs ignored.
REQ-016 LANG: lang_valid -> PIN, lang <= lang_sel.
REQ-017 PIN: pin_valid&pin_ok -> MENU, tries cleared; pin_valid&!pin_ok -> tries+1, err_code 1, stay PIN; reaching PIN_TRIES -> IDLE, card_retained pulse, err_code 2.
REQ-018 MENU: op_valid latches op/amount -> WITHDRAW/DEPOSIT/INQUIRY; op 11 -> EJECT.
REQ-019 WITHDRAW (one cycle): amount==0 or amount>balance -> err_code 3; withdrawn+amount>WD_LIMIT -> err_code 4 (3 takes priority); else balance-=amount, withdrawn+=amount, op_done; always -> MORE.
REQ-020 DEPOSIT (one cycle): amount==0 -> err_code 7; sum overflows BAL_W -> err_code 5, balance unchanged; else balance+=amount, op_done; -> MORE.
REQ-021 INQUIRY: op_done pulse, balance unchanged, -> MORE.
REQ-022 MORE: more_valid&more -> MENU; more_valid&!more -> EJECT.
REQ-023 EJECT: card_out one-cycle pulse -> IDLE.
REQ-024 op_done, err_valid, card_out, card_retained SHALL be single-cycle registered pulses; err_code holds until next err_valid.
REQ-025 Latency: accepted valid at edge N -> new state at N+1; WITHDRAW/DEPOSIT results (balance, op_done/err) visible after edge N+2.
REQ-026 Timer SHALL clear on every state change and every accepted valid; reaching TIMEOUT_CYC-1 in LANG/PIN/MENU/MORE -> EJECT, err_code 6.
REQ-027 Valid input and timeout expiry in same cycle: valid wins.
REQ-028 card_in outside IDLE SHALL be ignored; valids for non-current state ignored.
REQ-029 Arithmetic SHALL use BAL_W+1-bit intermediates; withdrawn counter saturates at WD_LIMIT.

Reset
REQ-030 rst low SHALL immediately force IDLE, balance 0, lang 0, all pulses 0, err_code 0, tries/timer/withdrawn 0, including mid-transaction.

Structure
REQ-031 State encodings, op codes and err_code values SHALL live in shared package atm_pkg.
REQ-032 Timeout counter SHALL be sub-module atm_timeout_timer (parameter TIMEOUT_CYC, clear, expire).

Verification
REQ-033 card_in, acct_balance=1000, English, pin ok, withdraw 300, more=0 -> balance 700, op_done once, card_out pulse, IDLE.
REQ-034 Three pin_ok=0 -> err_code 1,1 then 2, card_retained pulse, IDLE, no card_out.
REQ-035 Balance 1000, withdraw 1200 -> err_code 3, balance 1000; then WD_LIMIT=5000 session, balance 9000, withdraw 4000 then 2000 -> second err_code 4, balance 5000.
REQ-036 Balance 2^20-10, deposit 20 -> err_code 5, balance unchanged; deposit 5 -> 2^20-5.
REQ-037 MENU with no input TIMEOUT_CYC cycles -> err_code 6, card_out, IDLE; op_valid on expiry cycle -> operation taken instead.
REQ-038 rst asserted during WITHDRAW -> outputs at reset values same cycle, IDLE after release.
